// File: rtl/avst_frame_collector.sv
// avst_frame_collector: collects fixed-length Avalon-ST frames into a ping-pong buffer pair for random-access readout
// Optional feature macro: AVST_COLLECTOR_STATS_EN (enables saturating frame/error counters)
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_sop/in_eop/in_error/in_data   Avalon-ST sink (readyLatency 0)
//   frame_valid, frame_ack         oldest complete frame is presented / consumer releases it
//   rd_addr, rd_data               beat index and registered read data of the presented frame
//   err_pulse                      one-cycle pulse per framing or error-flag event
//   frame_cnt, err_cnt             statistics counters (zero when stats are disabled)
module avst_frame_collector #(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 39
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [1:0]                in_error,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      frame_valid,
  input  logic                      frame_ack,
  input  logic [$clog2(LENGTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      err_pulse,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_cnt
);
  localparam int AW = $clog2(LENGTH);
  localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);
  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;
  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_idx, w_idx_nxt, w_widx;
  logic               r_bad, w_bad_nxt, w_bad_eff;
  logic [1:0]         r_full, w_full_nxt;
  logic               r_wr_ptr, r_rd_ptr;
  logic               r_err, w_err, w_done, w_wr, w_acc, w_ack;
  logic [WIDTH-1:0]   r_rd_data;
  logic [WIDTH-1:0]   r_mem [2*LENGTH];
  assign in_ready    = !r_full[r_wr_ptr];
  assign frame_valid = r_full[r_rd_ptr];
  assign rd_data     = r_rd_data;
  assign err_pulse   = r_err;
  assign w_acc       = in_valid && in_ready;
  assign w_ack       = frame_ack && frame_valid;
  // An sop beat always restarts at index 0 and clears any badness of the abandoned frame
  assign w_widx      = in_sop ? '0 : r_idx;
  assign w_bad_eff   = (|in_error) || (!in_sop && r_bad);
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bad_nxt   = r_bad;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_wr        = 1'b0;
    if (w_acc) begin
      if (in_sop || r_state == FILL) begin
        w_wr  = 1'b1;
        w_err = in_sop && r_state == FILL;
        if (in_eop) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_bad_nxt   = 1'b0;
          if (w_widx == LAST && !w_bad_eff) w_done = 1'b1;
          else                              w_err  = 1'b1;
        end else if (w_widx == LAST) begin
          w_state_nxt = DROP;
          w_idx_nxt   = '0;
          w_bad_nxt   = 1'b0;
          w_err       = 1'b1;
        end else begin
          w_state_nxt = FILL;
          w_idx_nxt   = w_widx + AW'(1);
          w_bad_nxt   = w_bad_eff;
        end
      end else if (r_state == IDLE) begin
        w_err = 1'b1;
      end else if (in_eop) begin
        w_state_nxt = IDLE;
      end
    end
  end
  // Completion and ack can never target the same buffer, so both updates apply together
  always_comb begin
    w_full_nxt = r_full;
    if (w_ack)  w_full_nxt[r_rd_ptr] = 1'b0;
    if (w_done) w_full_nxt[r_wr_ptr] = 1'b1;
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[{r_wr_ptr, w_widx}] <= in_data;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_bad     <= 1'b0;
      r_full    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_bad     <= w_bad_nxt;
      r_full    <= w_full_nxt;
      r_wr_ptr  <= r_wr_ptr ^ w_done;
      r_rd_ptr  <= r_rd_ptr ^ w_ack;
      r_err     <= w_err;
      r_rd_data <= r_mem[{r_rd_ptr, rd_addr}];
    end
  end
`ifdef AVST_COLLECTOR_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_done && !(&r_frame_cnt)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err && !(&r_err_cnt))    r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif
endmodule
